// File: rtl/riscv_rvfi_check.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_rvfi_check
//  Purpose  : Online RVFI retirement checker. Tracks retirement order, PC
//             continuity, x0 behaviour and a shadow register file, and
//             latches the first detected error code until reset.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_rvfi_check #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            rvfi_valid,
  input  logic [63:0]     rvfi_order,
  input  logic            rvfi_trap,
  input  logic            rvfi_halt,
  input  logic            rvfi_intr,
  input  logic [4:0]      rvfi_rs1_addr,
  input  logic [4:0]      rvfi_rs2_addr,
  input  logic [4:0]      rvfi_rd_addr,
  input  logic [XLEN-1:0] rvfi_rs1_rdata,
  input  logic [XLEN-1:0] rvfi_rs2_rdata,
  input  logic [XLEN-1:0] rvfi_rd_wdata,
  input  logic [XLEN-1:0] rvfi_pc_rdata,
  input  logic [XLEN-1:0] rvfi_pc_wdata,
  output logic [15:0]     errcode,
  output logic            error,
  output logic            halted
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam logic [15:0] E_ORDER = 16'h0101;
  localparam logic [15:0] E_PC    = 16'h0102;
  localparam logic [15:0] E_X0    = 16'h0103;
  localparam logic [15:0] E_RS1   = 16'h0104;
  localparam logic [15:0] E_RS2   = 16'h0105;
  localparam logic [15:0] E_ALIGN = 16'h0106;
  localparam logic [15:0] E_HALT  = 16'h0107;

  state_t            state, state_nxt;
  logic [63:0]       exp_order;
  logic [XLEN-1:0]   prev_pc;
  logic [XLEN-1:0]   shadow_data [1:31];
  logic [31:1]       shadow_valid;

  logic [63:0]       order_ref;
  logic              rs1_bad, rs2_bad;
  logic [15:0]       code;
  logic              fail, accept, shadow_we;

  // Evaluate all checks on the current retirement; the first failing check
  // in code order wins, and a retirement after halt masks everything else.
  always_comb begin
    order_ref = (state == IDLE) ? 64'd0 : exp_order;
    rs1_bad   = 1'b0;
    rs2_bad   = 1'b0;
    code      = 16'h0000;
    if (rvfi_rs1_addr == 5'd0)
      rs1_bad = (rvfi_rs1_rdata != '0);
    else
      rs1_bad = shadow_valid[rvfi_rs1_addr] && (rvfi_rs1_rdata != shadow_data[rvfi_rs1_addr]);
    if (rvfi_rs2_addr == 5'd0)
      rs2_bad = (rvfi_rs2_rdata != '0);
    else
      rs2_bad = shadow_valid[rvfi_rs2_addr] && (rvfi_rs2_rdata != shadow_data[rvfi_rs2_addr]);

    if (rvfi_valid && (state != ERROR)) begin
      if (state == HALTED)
        code = E_HALT;
      else if (rvfi_order != order_ref)
        code = E_ORDER;
      else if ((state != IDLE) && !rvfi_intr && (rvfi_pc_rdata != prev_pc))
        code = E_PC;
      else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0))
        code = E_X0;
      else if (rs1_bad)
        code = E_RS1;
      else if (rs2_bad)
        code = E_RS2;
      else if (rvfi_pc_wdata[0] && !rvfi_trap)
        code = E_ALIGN;
    end
    fail      = (code != 16'h0000);
    accept    = rvfi_valid && ((state == IDLE) || (state == RUN)) && !fail;
    shadow_we = accept && !rvfi_trap && (rvfi_rd_addr != 5'd0);
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: any failure is terminal, a clean halt parks in HALTED.
  always_comb begin
    state_nxt = state;
    if (fail)
      state_nxt = ERROR;
    else if (accept)
      state_nxt = rvfi_halt ? HALTED : RUN;
  end

  // Error latch, order/PC history and shadow valid bits.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      errcode      <= 16'h0000;
      error        <= 1'b0;
      halted       <= 1'b0;
      exp_order    <= 64'd0;
      prev_pc      <= '0;
      shadow_valid <= '0;
    end else begin
      if (fail) begin
        errcode <= code;
        error   <= (code != 16'h0000);
      end
      if (accept) begin
        exp_order <= rvfi_order + 64'd1;
        prev_pc   <= rvfi_pc_wdata;
        if (rvfi_halt)
          halted <= 1'b1;
      end
      if (shadow_we)
        shadow_valid[rvfi_rd_addr] <= 1'b1;
    end
  end

  // Shadow data needs no reset: it is only consulted behind its valid bit.
  always_ff @(posedge clock) begin
    if (shadow_we)
      shadow_data[rvfi_rd_addr] <= rvfi_rd_wdata;
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_rvfi_check.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_rvfi_check
//  Purpose  : Self-checking bench for riscv_rvfi_check (vector table plus
//             hand-written reset / X-input sequences, scoreboard compare).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_rvfi_check;

  logic        clk;
  logic        reset_n;
  logic        valid;
  logic [63:0] order;
  logic        trap, halt, intr;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_rdata, rs2_rdata, rd_wdata, pc_rdata, pc_wdata;
  logic [15:0] errcode;
  logic        error, halted;

  riscv_rvfi_check #(.XLEN(32)) dut (
    .clock(clk), .reset_n(reset_n),
    .rvfi_valid(valid), .rvfi_order(order),
    .rvfi_trap(trap), .rvfi_halt(halt), .rvfi_intr(intr),
    .rvfi_rs1_addr(rs1_addr), .rvfi_rs2_addr(rs2_addr), .rvfi_rd_addr(rd_addr),
    .rvfi_rs1_rdata(rs1_rdata), .rvfi_rs2_rdata(rs2_rdata), .rvfi_rd_wdata(rd_wdata),
    .rvfi_pc_rdata(pc_rdata), .rvfi_pc_wdata(pc_wdata),
    .errcode(errcode), .error(error), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [63:0] order;
    logic [31:0] pcr, pcw;
    bit          trap, halt, intr;
    logic [4:0]  rs1;
    logic [31:0] rs1d;
    logic [4:0]  rs2;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic [31:0] rdd;
    logic [15:0] exp_err;
    bit          exp_halt;
  } vec_t;

  typedef struct {
    logic [15:0] err;
    bit          hlt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(bit rst, logic [63:0] o, logic [31:0] pcr, logic [31:0] pcw,
                              bit tr, bit hl, bit it,
                              logic [4:0] r1, logic [31:0] r1d, logic [4:0] r2, logic [31:0] r2d,
                              logic [4:0] rd, logic [31:0] rdd, logic [15:0] e, bit eh);
    vec_t v;
    v.rst = rst; v.order = o; v.pcr = pcr; v.pcw = pcw;
    v.trap = tr; v.halt = hl; v.intr = it;
    v.rs1 = r1; v.rs1d = r1d; v.rs2 = r2; v.rs2d = r2d;
    v.rd = rd; v.rdd = rdd; v.exp_err = e; v.exp_halt = eh;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid = 1'b0; order = '0; trap = 0; halt = 0; intr = 0;
    rs1_addr = '0; rs2_addr = '0; rd_addr = '0;
    rs1_rdata = '0; rs2_rdata = '0; rd_wdata = '0; pc_rdata = '0; pc_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic compare_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".errcode"}, errcode, e.err);
    check({tag, ".error"}, {15'd0, error}, {15'd0, (e.err != 16'h0)});
    check({tag, ".halted"}, {15'd0, halted}, {15'd0, e.hlt});
  endtask

  // Drive one retirement, push its expectation, pop and compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    if (v.rst) do_reset();
    @(negedge clk);
    valid = 1'b1; order = v.order; trap = v.trap; halt = v.halt; intr = v.intr;
    rs1_addr = v.rs1; rs1_rdata = v.rs1d; rs2_addr = v.rs2; rs2_rdata = v.rs2d;
    rd_addr = v.rd; rd_wdata = v.rdd; pc_rdata = v.pcr; pc_wdata = v.pcw;
    e.err = v.exp_err; e.hlt = v.exp_halt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    valid = 1'b0;
    compare_pop(tag);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();

    // Legal run 0,1,2 with continuous PCs
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 32'h4, 32'h8, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0));
    vecs.push_back(mk(0, 2, 32'h8, 32'hC, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0));
    // Order skip 0,1,3 then sticky
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 32'h4, 32'h8, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0));
    vecs.push_back(mk(0, 3, 32'h8, 32'hC, 0,0,0, 0,0, 0,0, 0,0, 16'h0101, 0));
    vecs.push_back(mk(0, 2, 32'h8, 32'hC, 0,0,0, 0,0, 0,0, 0,0, 16'h0101, 0));
    // Bad PC and bad rs1 together: PC code wins
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,0,0, 0,0, 0,0, 5,32'h1234, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 32'h8, 32'hC, 0,0,0, 5,32'h1235, 0,0, 0,0, 16'h0102, 0));
    // Bad rs1 alone, back-to-back with the write
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,0,0, 0,0, 0,0, 5,32'h1234, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 32'h4, 32'h8, 0,0,0, 5,32'h1235, 0,0, 0,0, 16'h0104, 0));
    // Reset clears shadow valid bits
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,0,0, 5,32'h7, 0,0, 0,0, 16'h0000, 0));
    // rd==rs1 uses old value; rs2 compares new then old value
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,0,0, 0,0, 0,0, 7,32'hAA, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 32'h4, 32'h8, 0,0,0, 7,32'hAA, 0,0, 7,32'hBB, 16'h0000, 0));
    vecs.push_back(mk(0, 2, 32'h8, 32'hC, 0,0,0, 0,0, 7,32'hBB, 0,0, 16'h0000, 0));
    vecs.push_back(mk(0, 3, 32'hC, 32'h10, 0,0,0, 0,0, 7,32'hAA, 0,0, 16'h0105, 0));
    // x0 write, x0 reads, rs1 beats misalignment
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,0,0, 0,0, 0,0, 0,32'h1, 16'h0103, 0));
    vecs.push_back(mk(1, 0, 32'h0, 32'h5, 0,0,0, 0,32'h5, 0,0, 0,0, 16'h0104, 0));
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,0,0, 0,0, 0,32'h9, 0,0, 16'h0105, 0));
    // Misaligned next PC: error without trap, allowed with trap
    vecs.push_back(mk(1, 0, 32'h0, 32'h5, 0,0,0, 0,0, 0,0, 0,0, 16'h0106, 0));
    vecs.push_back(mk(1, 0, 32'h0, 32'h5, 1,0,0, 0,0, 0,0, 0,0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 32'h5, 32'h8, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0));
    // Halt from IDLE, then a retirement with wrong order: only 0x0107
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,1,0, 0,0, 0,0, 0,0, 16'h0000, 1));
    vecs.push_back(mk(0, 5, 32'h40, 32'h44, 0,0,0, 0,0, 0,0, 0,0, 16'h0107, 1));
    // Halt from RUN
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 32'h4, 32'h8, 0,1,0, 0,0, 0,0, 0,0, 16'h0000, 1));
    vecs.push_back(mk(0, 2, 32'h8, 32'hC, 0,0,0, 0,0, 0,0, 0,0, 16'h0107, 1));
    // Interrupt entry skips PC check; trapped rd write is not shadowed
    vecs.push_back(mk(1, 0, 32'h0, 32'h4, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0));
    vecs.push_back(mk(0, 1, 32'h100, 32'h104, 0,0,1, 0,0, 0,0, 0,0, 16'h0000, 0));
    vecs.push_back(mk(0, 2, 32'h104, 32'h200, 1,0,0, 0,0, 0,0, 3,32'h55, 16'h0000, 0));
    vecs.push_back(mk(0, 3, 32'h200, 32'h204, 0,0,0, 3,32'h99, 0,0, 0,0, 16'h0000, 0));
    // First retirement must be order 0; first PC is unchecked
    vecs.push_back(mk(1, 1, 32'h0, 32'h4, 0,0,0, 0,0, 0,0, 0,0, 16'h0101, 0));
    vecs.push_back(mk(1, 0, 32'h1234, 32'h1238, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0));

    // Reset state
    #2;
    check("reset.errcode", errcode, 16'h0000);
    check("reset.error", {15'd0, error}, 16'h0000);
    check("reset.halted", {15'd0, halted}, 16'h0000);

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset after a latched error, away from any clock edge
    apply(mk(1, 0, 32'h0, 32'h4, 0,1,0, 0,0, 0,0, 0,0, 16'h0000, 1), "pre_err0");
    apply(mk(0, 9, 32'h4, 32'h8, 0,0,0, 0,0, 0,0, 0,0, 16'h0107, 1), "pre_err1");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #2;
    check("async_rst.errcode", errcode, 16'h0000);
    check("async_rst.error", {15'd0, error}, 16'h0000);
    check("async_rst.halted", {15'd0, halted}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(0, 0, 32'h500, 32'h504, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0), "post_rst");

    // X on every input while valid=0 must not disturb state or outputs
    @(negedge clk);
    order = 'x; trap = 'x; halt = 'x; intr = 'x;
    rs1_addr = 'x; rs2_addr = 'x; rd_addr = 'x;
    rs1_rdata = 'x; rs2_rdata = 'x; rd_wdata = 'x; pc_rdata = 'x; pc_wdata = 'x;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("xin%0d.errcode", c), errcode, 16'h0000);
      check($sformatf("xin%0d.flags", c), {14'd0, error, halted}, 16'h0000);
    end
    apply(mk(0, 1, 32'h504, 32'h508, 0,0,0, 0,0, 0,0, 0,0, 16'h0000, 0), "after_x");

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
